// File: rtl/axis_gen_pkg.sv
// Shared types and LFSR helper for the AXI-Stream pattern generator.
package axis_gen_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK  = 2'd3
  } mode_t;

  // Feedback taps for x^32+x^22+x^2+x+1 (bit positions 31, 21, 1, 0).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_gen_pattern.sv
// Data-pattern source: loaded at run start, stepped once per accepted beat.
module axis_gen_pattern
  import axis_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] seed,
  input  mode_t                 mode,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] data
);

  mode_t                 mode_reg;
  logic [DATA_WIDTH-1:0] value_reg;
  logic [31:0]           lfsr_reg;
  logic [31:0]           seed32;
  logic [31:0]           lfsr_load;
  logic [DATA_WIDTH-1:0] lfsr_data;

  // The LFSR is always 32 bits; adapt it to the stream width in both directions.
  for (genvar gi = 0; gi < 32; gi++) begin : g_seed
    if (gi < DATA_WIDTH) begin : g_bit
      assign seed32[gi] = seed[gi];
    end else begin : g_zero
      assign seed32[gi] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_lfsr_out
    if (gi < 32) begin : g_bit
      assign lfsr_data[gi] = lfsr_reg[gi];
    end else begin : g_zero
      assign lfsr_data[gi] = 1'b0;
    end
  end

  assign lfsr_load = (seed32 == 32'd0) ? 32'd1 : seed32;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      mode_reg  <= MODE_INC;
      value_reg <= '0;
      lfsr_reg  <= '0;
    end else if (load) begin
      mode_reg  <= mode;
      lfsr_reg  <= lfsr_load;
      value_reg <= (mode == MODE_WALK) ? DATA_WIDTH'(1) : seed;
    end else if (advance) begin
      case (mode_reg)
        MODE_INC:  value_reg <= value_reg + DATA_WIDTH'(1);
        MODE_LFSR: lfsr_reg  <= lfsr_next(lfsr_reg);
        MODE_WALK: value_reg <= {value_reg[DATA_WIDTH-2:0], value_reg[DATA_WIDTH-1]};
        default:   value_reg <= value_reg;
      endcase
    end
  end

  assign data = (mode_reg == MODE_LFSR) ? lfsr_data : value_reg;

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI-Stream master emitting programmed runs of framed test packets.
module axis_pattern_gen
  import axis_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [LEN_WIDTH-1:0]  cfg_num_pkts,
  input  logic [LEN_WIDTH-1:0]  cfg_gap,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           beats_sent,
  output logic [LEN_WIDTH-1:0]  pkts_sent
);

  state_t               state_reg, state_next;
  logic [LEN_WIDTH-1:0] len_reg, num_reg, gap_reg;
  logic [LEN_WIDTH-1:0] beat_idx_reg, gap_cnt_reg, pkts_sent_reg;
  logic [31:0]          beats_sent_reg;
  logic                 start_ok, beat_acc, last_acc, run_end;

  assign start_ok = (state_reg == IDLE) && start &&
                    (cfg_pkt_len != '0) && (cfg_num_pkts != '0);

  assign m_axis_tvalid = (state_reg == SEND);
  assign m_axis_tlast  = m_axis_tvalid && (beat_idx_reg == len_reg - LEN_WIDTH'(1));
  assign beat_acc      = m_axis_tvalid && m_axis_tready;
  assign last_acc      = beat_acc && m_axis_tlast;
  // Abort is only honoured at a packet boundary, so packets always close with tlast.
  assign run_end       = (pkts_sent_reg + LEN_WIDTH'(1) == num_reg) || abort;

  assign busy       = (state_reg == SEND) || (state_reg == GAP);
  assign done       = (state_reg == DONE);
  assign beats_sent = beats_sent_reg;
  assign pkts_sent  = pkts_sent_reg;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start_ok) state_next = SEND;
      SEND: begin
        if (last_acc) begin
          if (run_end)              state_next = DONE;
          else if (gap_reg != '0)   state_next = GAP;
          else                      state_next = SEND;
        end
      end
      GAP: begin
        if (abort)                                state_next = DONE;
        else if (gap_cnt_reg == LEN_WIDTH'(1))    state_next = SEND;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      len_reg        <= '0;
      num_reg        <= '0;
      gap_reg        <= '0;
      beat_idx_reg   <= '0;
      gap_cnt_reg    <= '0;
      pkts_sent_reg  <= '0;
      beats_sent_reg <= '0;
    end else if (start_ok) begin
      len_reg        <= cfg_pkt_len;
      num_reg        <= cfg_num_pkts;
      gap_reg        <= cfg_gap;
      beat_idx_reg   <= '0;
      pkts_sent_reg  <= '0;
      beats_sent_reg <= '0;
    end else begin
      if (beat_acc) begin
        if (beats_sent_reg != 32'hFFFF_FFFF) beats_sent_reg <= beats_sent_reg + 32'd1;
        if (m_axis_tlast) begin
          beat_idx_reg  <= '0;
          pkts_sent_reg <= pkts_sent_reg + LEN_WIDTH'(1);
          gap_cnt_reg   <= gap_reg;
        end else begin
          beat_idx_reg  <= beat_idx_reg + LEN_WIDTH'(1);
        end
      end
      if (state_reg == GAP) gap_cnt_reg <= gap_cnt_reg - LEN_WIDTH'(1);
    end
  end

  axis_gen_pattern #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pattern (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .load    (start_ok),
    .seed    (cfg_seed),
    .mode    (mode_t'(cfg_mode)),
    .advance (beat_acc),
    .data    (m_axis_tdata)
  );

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Bench for axis_pattern_gen: per-run beat queue model checked every cycle.
module tb_axis_pattern_gen;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] cfg_pkt_len = '0;
  logic [LW-1:0] cfg_num_pkts = '0;
  logic [LW-1:0] cfg_gap = '0;
  logic [1:0]    cfg_mode = '0;
  logic [DW-1:0] cfg_seed = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic [31:0]   beats_sent;
  logic [LW-1:0] pkts_sent;

  axis_pattern_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .start         (start),
    .abort         (abort),
    .cfg_pkt_len   (cfg_pkt_len),
    .cfg_num_pkts  (cfg_num_pkts),
    .cfg_gap       (cfg_gap),
    .cfg_mode      (cfg_mode),
    .cfg_seed      (cfg_seed),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .beats_sent    (beats_sent),
    .pkts_sent     (pkts_sent)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    run_gap = 0;
  int    gap_rem = 0;
  bit    done_pending = 1'b0;
  int    bp_mode = 0;   // 0: ready high, 1: random, 2: held low
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference LFSR written directly from the polynomial exponents.
  function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
    int taps[4] = '{32, 22, 2, 1};
    logic fb = 1'b0;
    for (int i = 0; i < 4; i++) fb = fb ^ s[taps[i]-1];
    return {s[30:0], fb};
  endfunction

  task automatic build_run(input int mode, input logic [31:0] seed, input int len,
                           input int pkts, input int gap);
    logic [31:0] lf;
    beat_t       b;
    run_gap = gap;
    lf = (seed == 32'd0) ? 32'd1 : seed;
    for (int k = 0; k < len * pkts; k++) begin
      case (mode)
        0:       b.data = seed + 32'(k);
        1:       b.data = lf;
        2:       b.data = seed;
        default: b.data = 32'd1 << (k % DW);
      endcase
      lf     = ref_lfsr(lf);
      b.last = ((k % len) == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic launch(input int mode, input logic [31:0] seed, input int len, input int pkts,
                        input int gap, input bit expect_run, input int model_pkts);
    @(posedge ACLK); #1;
    cfg_mode     = 2'(mode);
    cfg_seed     = seed;
    cfg_pkt_len  = LW'(len);
    cfg_num_pkts = LW'(pkts);
    cfg_gap      = LW'(gap);
    start        = 1'b1;
    @(posedge ACLK);
    if (expect_run) build_run(mode, seed, len, model_pkts, gap);
    #1;
    start = 1'b0;
    // Scramble the config inputs: a running packet stream must not notice.
    cfg_mode     = 2'($urandom);
    cfg_seed     = $urandom;
    cfg_pkt_len  = LW'($urandom_range(1, 9));
    cfg_num_pkts = LW'($urandom_range(1, 9));
    cfg_gap      = LW'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || done_pending) && i < budget) begin
      @(negedge ACLK);
      i++;
    end
    if (i >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: %0d beats still outstanding after %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic wait_q_le(input int n, input int budget);
    int i = 0;
    while (exp_q.size() > n && i < budget) begin
      @(negedge ACLK);
      i++;
    end
    if (i >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL progress_timeout: queue %0d, wanted <= %0d", exp_q.size(), n);
    end
  endtask

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge ACLK); #1;
      if (bp_mode == 1)      m_axis_tready = 1'($urandom_range(0, 1));
      else if (bp_mode == 2) m_axis_tready = 1'b0;
      else                   m_axis_tready = 1'b1;
    end
  end

  // Cycle-by-cycle compare against the model timeline.
  initial begin
    bit    exp_valid;
    bit    done_now;
    beat_t b;
    forever begin
      @(negedge ACLK);
      exp_valid    = (exp_q.size() != 0) && (gap_rem == 0);
      done_now     = done_pending;
      done_pending = 1'b0;
      check("tvalid", 64'(m_axis_tvalid), 64'(exp_valid));
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      check("done", 64'(done), 64'(done_now));
      if (gap_rem > 0) gap_rem--;
      if (m_axis_tvalid && exp_valid) begin
        check("tdata", 64'(m_axis_tdata), 64'(exp_q[0].data));
        check("tlast", 64'(m_axis_tlast), 64'(exp_q[0].last));
        if (m_axis_tready) begin
          b = exp_q.pop_front();
          $display("beat data=%08h last=%0d left=%0d", b.data, b.last, exp_q.size());
          if (exp_q.size() == 0) done_pending = 1'b1;
          else if (b.last)       gap_rem = run_gap;
        end
      end
    end
  end

  initial begin
    #23;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_beats", 64'(beats_sent), 64'd0);
    check("rst_pkts", 64'(pkts_sent), 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0;

    // Incrementing stream, back-to-back packets.
    launch(0, 32'h100, 4, 2, 0, 1'b1, 2);
    check("model_inc_first", 64'(exp_q[0].data), 64'h100);
    check("model_inc_last", 64'(exp_q[7].data), 64'h107);
    check("model_inc_tlast3", 64'(exp_q[3].last), 64'd1);
    wait_done(100);
    check("t1_beats", 64'(beats_sent), 64'd8);
    check("t1_pkts", 64'(pkts_sent), 64'd2);

    // LFSR under random backpressure, including a long stall.
    bp_mode = 1;
    launch(1, 32'hACE1, 5, 3, 0, 1'b1, 3);
    check("model_lfsr0", 64'(exp_q[0].data), 64'hACE1);
    check("model_lfsr1", 64'(exp_q[1].data), 64'h159C3);
    check("model_lfsr2", 64'(exp_q[2].data), 64'h2B386);
    repeat (6) @(negedge ACLK);
    bp_mode = 2;
    repeat (30) @(negedge ACLK);
    bp_mode = 1;
    wait_done(2000);
    bp_mode = 0;
    check("t2_beats", 64'(beats_sent), 64'd15);
    check("t2_pkts", 64'(pkts_sent), 64'd3);

    // Inter-packet gaps (timing enforced by the compare process).
    launch(2, 32'h5A5A5A5A, 2, 3, 3, 1'b1, 3);
    wait_done(200);
    check("t3_beats", 64'(beats_sent), 64'd6);
    check("t3_pkts", 64'(pkts_sent), 64'd3);

    // Abort during packet 1: that packet still completes.
    launch(0, 32'h0, 8, 10, 0, 1'b1, 2);
    wait_q_le(5, 200);
    abort = 1'b1;
    wait_done(200);
    abort = 1'b0;
    check("t4_beats", 64'(beats_sent), 64'd16);
    check("t4_pkts", 64'(pkts_sent), 64'd2);

    // Zero length / zero count starts are ignored.
    launch(0, 32'h0, 0, 5, 0, 1'b0, 0);
    repeat (4) @(negedge ACLK);
    launch(0, 32'h0, 4, 0, 0, 1'b0, 0);
    repeat (4) @(negedge ACLK);
    check("t5_beats_held", 64'(beats_sent), 64'd16);

    // Start while busy with different config has no effect.
    launch(0, 32'h10, 3, 2, 1, 1'b1, 2);
    launch(3, 32'h0, 7, 9, 0, 1'b0, 0);
    wait_done(200);
    check("t6_beats", 64'(beats_sent), 64'd6);
    check("t6_pkts", 64'(pkts_sent), 64'd2);

    // Asynchronous reset in the middle of a packet.
    launch(0, 32'h40, 6, 1, 0, 1'b1, 1);
    wait_q_le(4, 100);
    #2;
    ARESET = 1'b1;
    exp_q.delete();
    gap_rem      = 0;
    done_pending = 1'b0;
    #1;
    check("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_beats", 64'(beats_sent), 64'd0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    launch(3, 32'hFFFF, 4, 1, 0, 1'b1, 1);
    check("model_walk3", 64'(exp_q[3].data), 64'h8);
    check("model_walk3_last", 64'(exp_q[3].last), 64'd1);
    wait_done(100);
    check("t7_beats", 64'(beats_sent), 64'd4);
    check("t7_pkts", 64'(pkts_sent), 64'd1);

    repeat (3) @(negedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_pattern_gen.md
Name: axis_pattern_gen

Overview:
AXI-Stream master that generates framed test traffic for the AXI-Lite-controlled stream FIFO sink. It drives that sink's s_axis_tdata/tvalid/tlast and accepts its s_axis_tready. A start pulse launches a programmed number of packets of programmed length, with a selectable data pattern and inter-packet gap. Busy, done and counter outputs let a register block or bench observe progress.

Parameters:
DATA_WIDTH, 32, stream data width; the LFSR is 32-bit and is zero-extended or truncated to DATA_WIDTH.
LEN_WIDTH, 16, width of the packet-length, packet-count and gap fields.

Ports:
ACLK  in  1  clock, rising edge.
ARESET  in  1  asynchronous, active-high reset.
start  in  1  one-cycle launch pulse.
abort  in  1  level; stop at next packet boundary.
cfg_pkt_len  in  LEN_WIDTH  beats per packet.
cfg_num_pkts  in  LEN_WIDTH  packets per run.
cfg_gap  in  LEN_WIDTH  idle cycles between packets.
cfg_mode  in  2  pattern: 0 increment, 1 LFSR, 2 constant, 3 walking-one.
cfg_seed  in  DATA_WIDTH  initial value for increment/LFSR/constant.
m_axis_tdata  out  DATA_WIDTH  beat data.
m_axis_tvalid  out  1  beat valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  last beat of packet.
busy  out  1  high from start acceptance to completion.
done  out  1  one-cycle pulse when a run completes or is aborted.
beats_sent  out  32  accepted beats since last start, saturating.
pkts_sent  out  LEN_WIDTH  completed packets since last start.

Behaviour:
- Reset: all outputs 0; state IDLE; LFSR is loaded with cfg_seed on the next accepted start.
- Reset is asynchronous. Asserting it mid-packet drops tvalid immediately; no tlast is emitted. This is the only permitted tvalid withdrawal.
- State IDLE: a start with cfg_pkt_len!=0 and cfg_num_pkts!=0 latches all cfg_* inputs, clears both counters, sets busy and enters SEND.
  - tvalid rises on the cycle after start (latency 1).
  - A start with a zero length or count is ignored: no busy, no done.
- Start while busy: ignored. cfg_* changes while busy: no effect.
- State SEND: tvalid=1. A beat is accepted when tvalid&&tready.
  - tdata and tlast are held stable while tvalid&&!tready.
  - tlast=1 exactly on beat index cfg_pkt_len-1. A length of 1 gives tlast on every beat.
- Beat transfer: the pattern advances, beats_sent increments (saturating at 2^32-1), and the beat index increments.
- Last-beat transfer: pkts_sent increments and the beat index resets. Next state is:
  - DONE, if pkts_sent+1==cfg_num_pkts or abort=1;
  - GAP, if cfg_gap!=0;
  - otherwise SEND, with the next packet's first beat valid on the following cycle (back-to-back, no bubble).
- State GAP: tvalid=0 for exactly cfg_gap cycles, then SEND. abort in GAP goes to DONE on the next cycle.
- abort during SEND does not truncate the current packet; the packet always ends with tlast.
- State DONE: one cycle. done=1, busy drops in the same cycle, then IDLE. Counters hold until the next accepted start.
- Patterns (the value for beat k of a run continues across packets; it does not restart per packet):
  - mode 0 increment: seed+k, modulo 2^DATA_WIDTH.
  - mode 1 LFSR: Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1. The first beat is the seed. A seed of 0 is replaced by 32'h1.
  - mode 2 constant: seed on every beat.
  - mode 3 walking-one: 1<<(k mod DATA_WIDTH); seed is ignored.
- Backpressure: any tready pattern, including tready held low indefinitely, leaves the stream frozen with no lost or duplicated beats.

Decomposition:
- Package axis_gen_pkg holds:
  - state enum {IDLE, SEND, GAP, DONE};
  - pattern-mode enum;
  - LFSR tap constant;
  - function lfsr_next().
- One sub-module, axis_gen_pattern: holds the current data value, with load(seed, mode) and advance inputs. It keeps the pattern logic separate from framing and handshakes.

Test Plan:
- Stream-level test (tready high): mode 0, seed 0x100, len 4, pkts 2, gap 0 → 8 beats 0x100..0x107, tlast on beats 3 and 7, no bubbles; done 1 cycle after last beat; beats_sent=8, pkts_sent=2.
- Random backpressure: mode 1, seed 0xACE1, len 5, pkts 3, tready toggled randomly → tdata/tlast stable while stalled; sequence matches the reference LFSR model; 15 beats.
- Gap timing: len 2, pkts 3, gap 3 → exactly 3 tvalid-low cycles between the tlast transfer and the next first beat; never a gap after the final packet.
- Abort mid-packet: len 8, pkts 10; abort asserted at beat 3 of packet 1 → packet 1 completes to tlast; done pulses; pkts_sent=2; beats_sent=16.
- Illegal and overlapping starts: start with len 0 → busy stays 0 and no done; start while busy with different cfg → current run unchanged.
- Reset mid-packet: ARESET asserted during beat 2 → tvalid/busy/done are 0 immediately; after release, a new start with mode 3, len 4 gives 0x1, 0x2, 0x4, 0x8 with tlast on 0x8.
